// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with registered read ports,
// out-of-range detection and a clear sweep FSM. Optional macro: REGFILE_BYPASS_EN.
module regfile_param #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 6,
  parameter int AW    = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WR,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] LD_DATA,
  input  logic             RD,
  input  logic [AW-1:0]    RP,
  input  logic [AW-1:0]    RQ,
  input  logic             CLR_REQ,
  output logic [WIDTH-1:0] DATAP,
  output logic [WIDTH-1:0] DATAQ,
  output logic             VALID,
  output logic             BUSY,
  output logic             ERR,
  output logic             dbg_state
);

  // Handshake: RD/WR are single-cycle strobes honoured only while BUSY=0;
  // VALID is high for exactly the cycle after an accepted RD.

  typedef enum logic {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_t;

  localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);

  state_t           state, next_state;
  logic [AW-1:0]    ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             idle, wa_in, rp_in, rq_in, wr_ok, rd_ok, oor_hit;
  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd, rd_p, rd_q;

  assign idle      = (state == ST_IDLE);
  assign BUSY      = (state == ST_SWEEP);
  assign dbg_state = state;

  assign wa_in   = {1'b0, WA} < DEPTH_LIM;
  assign rp_in   = {1'b0, RP} < DEPTH_LIM;
  assign rq_in   = {1'b0, RQ} < DEPTH_LIM;
  assign wr_ok   = idle && WR && wa_in;
  assign rd_ok   = idle && RD;
  assign oor_hit = idle && ((WR && !wa_in) || (RD && (!rp_in || !rq_in)));

  always_comb begin
    next_state = state;
    if (state == ST_SWEEP) begin
      if (ptr == LAST_PTR) next_state = ST_IDLE;
    end else if (CLR_REQ) begin
      next_state = ST_SWEEP;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_SWEEP;
      ptr   <= '0;
    end else begin
      state <= next_state;
      if (state == ST_SWEEP) ptr <= (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
      else                   ptr <= '0;
    end
  end

  // Single write port shared by the sweep and normal writes; storage has no reset.
  assign mem_we = !RST && (BUSY || wr_ok);
  assign mem_wa = BUSY ? ptr : WA;
  assign mem_wd = BUSY ? '0 : LD_DATA;

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

`ifdef REGFILE_BYPASS_EN
  // Write-first: a same-cycle write to the read address is forwarded.
  assign rd_p = (wr_ok && RP == WA) ? LD_DATA : mem[RP];
  assign rd_q = (wr_ok && RQ == WA) ? LD_DATA : mem[RQ];
`else
  // Read-first: the old contents are returned; the new value shows next read.
  assign rd_p = mem[RP];
  assign rd_q = mem[RQ];
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      DATAP <= '0;
      DATAQ <= '0;
      VALID <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      VALID <= rd_ok;
      if (rd_ok) begin
        DATAP <= rp_in ? rd_p : '0;
        DATAQ <= rq_in ? rd_q : '0;
      end
      if (oor_hit) ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed scenarios plus randomized
// traffic against an array-based reference model.
module tb_regfile_param;
  localparam int WIDTH = 13;
  localparam int DEPTH = 6;
  localparam int AW    = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST, WR, RD, CLR_REQ;
  logic [AW-1:0]    WA, RP, RQ;
  logic [WIDTH-1:0] LD_DATA;
  logic [WIDTH-1:0] DATAP, DATAQ;
  logic             VALID, BUSY, ERR, dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  logic [WIDTH-1:0] mm [DEPTH];
  logic             err_m;
  logic [WIDTH-1:0] exp_p, exp_q;

  regfile_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .WR(WR), .WA(WA), .LD_DATA(LD_DATA), .RD(RD),
    .RP(RP), .RQ(RQ), .CLR_REQ(CLR_REQ), .DATAP(DATAP), .DATAQ(DATAQ),
    .VALID(VALID), .BUSY(BUSY), .ERR(ERR), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // driver tasks
  task automatic drive(input logic wr, input int wa, input logic [WIDTH-1:0] d,
                       input logic rd, input int rp, input int rq, input logic clr);
    WR = wr; WA = AW'(wa); LD_DATA = d; RD = rd; RP = AW'(rp); RQ = AW'(rq); CLR_REQ = clr;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 0, '0, 1'b0, 0, 0, 1'b0);
  endtask

  // model of one idle-state cycle using the current inputs
  task automatic model_cycle();
    if (RD) begin
      if (int'(RP) >= DEPTH) exp_p = '0;
      else if (BYP && WR && int'(WA) < DEPTH && WA == RP) exp_p = LD_DATA;
      else exp_p = mm[RP];
      if (int'(RQ) >= DEPTH) exp_q = '0;
      else if (BYP && WR && int'(WA) < DEPTH && WA == RQ) exp_q = LD_DATA;
      else exp_q = mm[RQ];
    end
    if (WR && int'(WA) < DEPTH) mm[WA] = LD_DATA;
    if ((WR && int'(WA) >= DEPTH) || (RD && (int'(RP) >= DEPTH || int'(RQ) >= DEPTH)))
      err_m = 1'b1;
  endtask

  // counts cycles with BUSY=1 starting now, bounded
  task automatic count_busy(output int cnt, input logic wr_noise);
    cnt = 0;
    while (BUSY === 1'b1 && cnt < 50) begin
      if (wr_noise) drive(1'b1, $urandom_range(0, DEPTH-1), 13'h1555, 1'b1, 0, 1, 1'b1);
      step();
      cnt++;
      n_checks++;
      if (VALID !== 1'b0) begin
        n_fail++; $display("FAIL sweep_valid: got %b want 0", VALID);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    int cnt;
    idle_inputs();
    RST = 1'b1; step(); RST = 1'b0;
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    err_m = 1'b0; exp_p = '0; exp_q = '0;
    n_checks++;
    if (DATAP !== '0 || DATAQ !== '0 || VALID !== 1'b0 || ERR !== 1'b0 || BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: p=%h q=%h v=%b e=%b b=%b want 0 0 0 0 1", DATAP, DATAQ, VALID, ERR, BUSY);
    end
    count_busy(cnt, 1'b0);
    n_checks++;
    if (cnt != DEPTH) begin n_fail++; $display("FAIL reset_busy_len: got %0d want %0d", cnt, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 0, '0, 1'b1, i, DEPTH-1-i, 1'b0);
      model_cycle(); step();
      n_checks++;
      if (VALID !== 1'b1 || DATAP !== exp_p || DATAQ !== exp_q) begin
        n_fail++; $display("FAIL reset_read[%0d]: v=%b p=%h q=%h want 1 %h %h", i, VALID, DATAP, DATAQ, exp_p, exp_q);
      end
    end
    idle_inputs(); step();
    n_checks++;
    if (VALID !== 1'b0) begin n_fail++; $display("FAIL valid_drop: got %b want 0", VALID); end
  endtask

  task automatic test_write_read();
    drive(1'b1, 2, 13'h1ABC, 1'b0, 0, 0, 1'b0); model_cycle(); step();
    drive(1'b0, 0, '0, 1'b1, 2, 2, 1'b0); model_cycle(); step();
    n_checks++;
    if (VALID !== 1'b1 || DATAP !== 13'h1ABC || DATAQ !== 13'h1ABC) begin
      n_fail++; $display("FAIL write_read: v=%b p=%h q=%h want 1 1abc 1abc", VALID, DATAP, DATAQ);
    end
    idle_inputs(); step(); step();
    n_checks++;
    if (VALID !== 1'b0 || DATAP !== 13'h1ABC || DATAQ !== 13'h1ABC) begin
      n_fail++; $display("FAIL hold: v=%b p=%h q=%h want 0 1abc 1abc", VALID, DATAP, DATAQ);
    end
  endtask

  task automatic test_same_cycle();
    drive(1'b1, 3, 13'h0055, 1'b1, 3, 2, 1'b0); model_cycle(); step();
    n_checks++;
    if (DATAP !== (BYP ? 13'h0055 : 13'h0000) || DATAQ !== 13'h1ABC) begin
      n_fail++; $display("FAIL same_cycle: p=%h q=%h want %h 1abc", DATAP, DATAQ, BYP ? 13'h0055 : 13'h0000);
    end
    drive(1'b0, 0, '0, 1'b1, 0, 3, 1'b0); model_cycle(); step();
    n_checks++;
    if (DATAQ !== 13'h0055 || DATAP !== 13'h0000) begin
      n_fail++; $display("FAIL same_cycle_next: p=%h q=%h want 0 0055", DATAP, DATAQ);
    end
  endtask

  task automatic test_out_of_range();
    drive(1'b0, 0, '0, 1'b1, 1, 0, 1'b0); model_cycle(); step();
    n_checks++;
    if (ERR !== 1'b0) begin n_fail++; $display("FAIL err_clean: got %b want 0", ERR); end
    drive(1'b1, 1, 13'h0777, 1'b0, 0, 0, 1'b0); model_cycle(); step();
    drive(1'b1, 6, 13'h1FFF, 1'b0, 0, 0, 1'b0); model_cycle(); step();
    n_checks++;
    if (ERR !== 1'b1) begin n_fail++; $display("FAIL err_wr_oor: got %b want 1", ERR); end
    for (int i = 0; i < DEPTH; i += 2) begin
      drive(1'b0, 0, '0, 1'b1, i, i+1, 1'b0); model_cycle(); step();
      n_checks++;
      if (DATAP !== exp_p || DATAQ !== exp_q) begin
        n_fail++; $display("FAIL oor_nochange[%0d]: p=%h q=%h want %h %h", i, DATAP, DATAQ, exp_p, exp_q);
      end
    end
    drive(1'b0, 0, '0, 1'b1, 7, 1, 1'b0); model_cycle(); step();
    n_checks++;
    if (DATAP !== '0 || DATAQ !== 13'h0777 || ERR !== 1'b1 || VALID !== 1'b1) begin
      n_fail++; $display("FAIL rd_oor_p: p=%h q=%h e=%b v=%b want 0 0777 1 1", DATAP, DATAQ, ERR, VALID);
    end
    drive(1'b0, 0, '0, 1'b1, 3, 6, 1'b0); model_cycle(); step();
    n_checks++;
    if (DATAP !== 13'h0055 || DATAQ !== '0) begin
      n_fail++; $display("FAIL rd_oor_q: p=%h q=%h want 0055 0", DATAP, DATAQ);
    end
  endtask

  task automatic test_clear();
    int cnt;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, i, WIDTH'(13'h0100 + i*13'h0111), 1'b0, 0, 0, 1'b0); model_cycle(); step();
    end
    // RD in the request cycle is still serviced
    drive(1'b0, 0, '0, 1'b1, 4, 5, 1'b1); model_cycle(); step();
    idle_inputs();
    n_checks++;
    if (VALID !== 1'b1 || DATAP !== exp_p || DATAQ !== exp_q || BUSY !== 1'b1) begin
      n_fail++; $display("FAIL clr_req_read: v=%b p=%h q=%h b=%b want 1 %h %h 1", VALID, DATAP, DATAQ, BUSY, exp_p, exp_q);
    end
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    count_busy(cnt, 1'b1);
    n_checks++;
    if (cnt != DEPTH) begin n_fail++; $display("FAIL clr_busy_len: got %0d want %0d", cnt, DEPTH); end
    n_checks++;
    if (ERR !== 1'b1) begin n_fail++; $display("FAIL clr_keeps_err: got %b want 1", ERR); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 0, '0, 1'b1, i, i, 1'b0); model_cycle(); step();
      n_checks++;
      if (DATAP !== '0 || DATAQ !== '0) begin
        n_fail++; $display("FAIL clr_read[%0d]: p=%h q=%h want 0 0", i, DATAP, DATAQ);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midsweep();
    int cnt;
    drive(1'b1, 0, 13'h0ABC, 1'b0, 0, 0, 1'b0); model_cycle(); step();
    drive(1'b0, 0, '0, 1'b1, 0, 0, 1'b0); model_cycle(); step();
    drive(1'b0, 0, '0, 1'b0, 0, 0, 1'b1); step();
    idle_inputs(); step(); step();
    RST = 1'b1; step(); RST = 1'b0;
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    err_m = 1'b0; exp_p = '0; exp_q = '0;
    n_checks++;
    if (DATAP !== '0 || DATAQ !== '0 || VALID !== 1'b0 || ERR !== 1'b0 || BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL midsweep_reset: p=%h q=%h v=%b e=%b b=%b want 0 0 0 0 1", DATAP, DATAQ, VALID, ERR, BUSY);
    end
    count_busy(cnt, 1'b0);
    n_checks++;
    if (cnt != DEPTH) begin n_fail++; $display("FAIL midsweep_busy_len: got %0d want %0d", cnt, DEPTH); end
  endtask

  task automatic test_random();
    logic rd;
    for (int n = 0; n < 300; n++) begin
      rd = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 7), WIDTH'($urandom),
            rd, $urandom_range(0, 7), $urandom_range(0, 7), 1'b0);
      model_cycle(); step();
      n_checks++;
      if (VALID !== rd || DATAP !== exp_p || DATAQ !== exp_q || ERR !== err_m || BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL random[%0d]: v=%b p=%h q=%h e=%b b=%b want %b %h %h %b 0",
                 n, VALID, DATAP, DATAQ, ERR, BUSY, rd, exp_p, exp_q, err_m);
      end
    end
    idle_inputs();
  endtask

  initial begin
    RST = 1'b0;
    idle_inputs();
    step();
    test_reset();
    test_write_read();
    test_same_cycle();
    test_out_of_range();
    test_clear();
    test_reset_midsweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
